// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared types and I/O window addresses for mem_io_responder
package mem_io_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam logic [1:0]  IO_BASE_SEL   = 2'b11;
    localparam logic [17:0] ADDR_UART     = 18'h30000;
    localparam logic [17:0] ADDR_CLK_STOP = 18'h30004;

endpackage

// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - CPU byte-wide memory bus between cpu and mem_io_responder
interface mem_io_responder_if;
    import mem_io_pkg::*;

    word_t mem_a;
    byte_t mem_wdata;
    logic  mem_wr;
    byte_t mem_rdata;
    logic  io_buffer_full;

    modport master (
        output mem_a, mem_wdata, mem_wr,
        input  mem_rdata, io_buffer_full
    );

    modport slave (
        input  mem_a, mem_wdata, mem_wr,
        output mem_rdata, io_buffer_full
    );

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with show-ahead head and occupancy count
module byte_fifo
    import mem_io_pkg::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  byte_t              push_data,
    input  logic               pop,
    output byte_t              head,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_LOG:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    byte_t                mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_LOG+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - 128 KB byte RAM plus UART FIFO / cycle counter / stop I/O window
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int TX_DEPTH_LOG = 4,
    parameter int RX_DEPTH_LOG = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_io_responder_if.slave bus,
    output logic              tx_valid,
    output byte_t             tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  byte_t             rx_data,
    output logic              rx_overflow,
    output logic              halted
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;

    byte_t             ram [2**ADDR_W];
    byte_t             ram_q;
    logic              rd_ram_q;
    byte_t             io_q;
    byte_t             io_rd_next;
    word_t             cycle_cnt;
    logic [31:8]       snap_hi;
    logic              stop_req;
    logic              halted_q;

    logic [17:0]       io_addr;
    logic [ADDR_W-1:0] ram_idx;
    logic              io;
    logic              ram_we;
    logic              io_wr;
    logic              io_rd;
    logic              unused_addr_bits;

    logic                  tx_push;
    byte_t                 tx_push_data;
    logic                  tx_empty;
    logic                  tx_full_unused;
    logic [TX_DEPTH_LOG:0] tx_count;

    logic                  rx_pop;
    logic                  rx_empty;
    logic                  rx_full;
    byte_t                 rx_head;
    logic [RX_DEPTH_LOG:0] rx_count_unused;

    assign io_addr          = bus.mem_a[17:0];
    assign ram_idx          = bus.mem_a[ADDR_W-1:0];
    assign unused_addr_bits = ^bus.mem_a[31:18];
    assign io               = (io_addr[17:16] == IO_BASE_SEL);
    assign ram_we           = bus.mem_wr && !io;
    assign io_wr            = bus.mem_wr && io;
    assign io_rd            = !bus.mem_wr && io;

    // The stop marker is a literal 0x00 and must not be caught by the zero filter.
    assign tx_push      = io_wr && (((io_addr == ADDR_UART) && (bus.mem_wdata != 8'h00))
                                    || (io_addr == ADDR_CLK_STOP));
    assign tx_push_data = (io_addr == ADDR_CLK_STOP) ? 8'h00 : bus.mem_wdata;
    assign rx_pop       = io_rd && (io_addr == ADDR_UART);

    byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_ready),
        .head      (tx_data),
        .full      (tx_full_unused),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count_unused)
    );

    assign tx_valid           = !tx_empty;
    assign bus.io_buffer_full = (TX_DEPTH - int'(tx_count)) <= FULL_MARGIN;
    assign halted             = halted_q || (stop_req && tx_empty);
    assign bus.mem_rdata      = rd_ram_q ? ram_q : io_q;

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= bus.mem_wdata;
        ram_q <= ram[ram_idx];
    end

    always_comb begin
        io_rd_next = 8'h00;
        if (io_rd) begin
            case (io_addr)
                ADDR_UART:             io_rd_next = rx_empty ? 8'h00 : rx_head;
                ADDR_CLK_STOP:         io_rd_next = cycle_cnt[7:0];
                ADDR_CLK_STOP + 18'd1: io_rd_next = snap_hi[15:8];
                ADDR_CLK_STOP + 18'd2: io_rd_next = snap_hi[23:16];
                ADDR_CLK_STOP + 18'd3: io_rd_next = snap_hi[31:24];
                default:               io_rd_next = 8'h00;
            endcase
        end
    end

    // rd_ram_q picks the RAM path; clearing it and io_q on reset zeroes an in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ram_q    <= 1'b0;
            io_q        <= 8'h00;
            cycle_cnt   <= '0;
            snap_hi     <= '0;
            stop_req    <= 1'b0;
            halted_q    <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rd_ram_q  <= !bus.mem_wr && !io;
            io_q      <= io_rd_next;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (io_rd && (io_addr == ADDR_CLK_STOP)) snap_hi <= cycle_cnt[31:8];
            if (io_wr && (io_addr == ADDR_CLK_STOP)) stop_req <= 1'b1;
            if (halted) halted_q <= 1'b1;
            if (rx_valid && rx_full && !rx_pop) rx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder
module tb_mem_io_responder;
    import mem_io_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  tx_valid;
    byte_t tx_data;
    logic  tx_ready;
    logic  rx_valid;
    byte_t rx_data;
    logic  rx_overflow;
    logic  halted;

    int checks = 0;
    int errors = 0;

    byte_t tx_seen [$];
    byte_t txq [$];
    byte_t rxq [$];
    byte_t ram_m [16];
    logic  m_ovf;
    logic  have_exp;
    byte_t exp_rd;
    logic  pop_tx, push_tx, m_rx_pop, got_empty;
    int    op, idx;
    byte_t d;
    byte_t exp_stop [4];

    typedef struct {
        logic        wr;
        logic [31:0] a;
        byte_t       d;
        logic        chk_rd;
        byte_t       exp;
    } vec_t;
    vec_t vecs [10];

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_overflow (rx_overflow),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_wr    = 1'b0;
        bus.mem_a     = 32'h0;
        bus.mem_wdata = 8'h00;
        rx_valid      = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input byte_t dat);
        bus.mem_a     = a;
        bus.mem_wdata = dat;
        bus.mem_wr    = 1'b1;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        bus.mem_a  = a;
        bus.mem_wr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        tx_ready = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        idle();
        step();
        chk("reset_rdata", bus.mem_rdata, 0);
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_full", bus.io_buffer_full, 0);
        chk("reset_overflow", rx_overflow, 0);
        chk("reset_halted", halted, 0);
        rst = 1'b0;

        // RAM and idle I/O window vectors
        vecs[0] = '{1'b1, 32'h00010, 8'hA5, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 32'h00010, 8'h00, 1'b1, 8'hA5};
        vecs[2] = '{1'b1, 32'h1FFFF, 8'h3C, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 32'h00000, 8'h77, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 32'h1FFFF, 8'h00, 1'b1, 8'h3C};
        vecs[5] = '{1'b0, 32'h00000, 8'h00, 1'b1, 8'h77};
        vecs[6] = '{1'b0, 32'h30008, 8'h00, 1'b1, 8'h00};
        vecs[7] = '{1'b0, 32'h30000, 8'h00, 1'b1, 8'h00};
        vecs[8] = '{1'b1, 32'h10010, 8'h5A, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 32'h10010, 8'h00, 1'b1, 8'h5A};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].a, vecs[i].d);
            else            bus_rd(vecs[i].a);
            step();
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), bus.mem_rdata, vecs[i].exp);
        end
        bus_rd(32'h00010);
        step();
        chk("ram_reread", bus.mem_rdata, 8'hA5);

        // TX zero filter
        do_reset();
        tx_ready = 1'b1;
        tx_seen.delete();
        bus_wr(32'h30000, 8'h48); step();
        bus_wr(32'h30000, 8'h00); step();
        bus_wr(32'h30000, 8'h69); step();
        idle(); step(); step();
        chk("tx_seq_len", tx_seen.size(), 2);
        if (tx_seen.size() == 2) begin
            chk("tx_seq_0", tx_seen[0], 8'h48);
            chk("tx_seq_1", tx_seen[1], 8'h69);
        end

        // TX nearly-full flag and full drop
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            bus_wr(32'h30000, 8'(i));
            step();
            chk($sformatf("tx_full_flag_%0d", i), bus.io_buffer_full,
                (16 - ((i > 16) ? 16 : i)) <= 2);
        end
        idle();
        tx_seen.delete();
        tx_ready = 1'b1;
        repeat (20) step();
        chk("tx_full_count", tx_seen.size(), 16);
        for (int i = 0; i < 16 && i < tx_seen.size(); i++)
            chk("tx_full_order", tx_seen[i], i + 1);

        // RX overflow and drain
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            step();
            chk($sformatf("rx_ovf_%0d", i), rx_overflow, i > 8);
        end
        rx_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus_rd(32'h30000);
            step();
            chk($sformatf("rx_pop_%0d", i), bus.mem_rdata, (i <= 8) ? i : 0);
        end
        chk("rx_ovf_sticky", rx_overflow, 1);

        // cycle counter snapshot and wrap
        do_reset();
        repeat (32'h1234) step();
        bus_rd(32'h30004); step();
        chk("cnt_lo", bus.mem_rdata, 8'h34);
        bus_rd(32'h30005); step();
        chk("cnt_snap1", bus.mem_rdata, 8'h12);
        bus_rd(32'h30006); step();
        chk("cnt_snap2", bus.mem_rdata, 8'h00);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        bus_rd(32'h30004);
        #3;
        release dut.cycle_cnt;
        step();
        chk("cnt_max_lo", bus.mem_rdata, 8'hFF);
        bus_rd(32'h30007); step();
        chk("cnt_max_snap3", bus.mem_rdata, 8'hFF);
        bus_rd(32'h30004); step();
        chk("cnt_wrap_lo", bus.mem_rdata, 8'h01);
        bus_rd(32'h30007); step();
        chk("cnt_wrap_snap3", bus.mem_rdata, 8'h00);

        // program stop and halt
        do_reset();
        exp_stop[0] = 8'h11; exp_stop[1] = 8'h22; exp_stop[2] = 8'h33; exp_stop[3] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            bus_wr(32'h30000, exp_stop[i]);
            step();
        end
        bus_wr(32'h30004, 8'h55); step();
        chk("stop_not_halted", halted, 0);
        idle();
        tx_seen.delete();
        tx_ready  = 1'b1;
        got_empty = 1'b0;
        for (int i = 0; i < 10 && !got_empty; i++) begin
            step();
            if (tx_valid) chk("halt_before_drain", halted, 0);
            else begin
                got_empty = 1'b1;
                chk("halt_on_drain", halted, 1);
            end
        end
        chk("halt_drain_seen", got_empty, 1);
        chk("stop_tx_len", tx_seen.size(), 4);
        for (int i = 0; i < 4 && i < tx_seen.size(); i++)
            chk("stop_tx_seq", tx_seen[i], exp_stop[i]);
        bus_wr(32'h30000, 8'h44); step();
        chk("post_stop_valid", tx_valid, 1);
        chk("post_stop_data", tx_data, 8'h44);
        chk("post_stop_halted", halted, 1);
        tx_ready = 1'b0;

        // asynchronous reset mid-stream
        for (int i = 0; i < 14; i++) begin
            bus_wr(32'h30000, 8'(i + 1));
            rx_valid = 1'b1;
            rx_data  = 8'(i + 1);
            step();
        end
        idle();
        bus_rd(32'h00010); step();
        chk("pre_rst_rdata", bus.mem_rdata, 8'hA5);
        chk("pre_rst_full", bus.io_buffer_full, 1);
        chk("pre_rst_ovf", rx_overflow, 1);
        chk("pre_rst_valid", tx_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_rdata", bus.mem_rdata, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_full", bus.io_buffer_full, 0);
        chk("rst_ovf", rx_overflow, 0);
        chk("rst_halted", halted, 0);
        step();
        rst = 1'b0;

        // randomized traffic against a queue model
        do_reset();
        for (int k = 0; k < 16; k++) begin
            ram_m[k] = 8'($urandom);
            bus_wr(32'h200 + k, ram_m[k]);
            step();
        end
        idle(); step();
        txq.delete(); rxq.delete();
        m_ovf    = 1'b0;
        have_exp = 1'b0;
        exp_rd   = 8'h00;
        for (int i = 0; i < 600; i++) begin
            chk("rnd_tx_valid", tx_valid, txq.size() != 0);
            if (txq.size() != 0) chk("rnd_tx_data", tx_data, txq[0]);
            chk("rnd_full", bus.io_buffer_full, (16 - txq.size()) <= 2);
            chk("rnd_ovf", rx_overflow, m_ovf);
            if (have_exp) chk("rnd_rdata", bus.mem_rdata, exp_rd);

            op       = $urandom_range(0, 7);
            idx      = $urandom_range(0, 15);
            d        = 8'($urandom);
            tx_ready = (i < 250) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            have_exp = 1'b1;
            exp_rd   = 8'h00;
            pop_tx   = tx_ready && (txq.size() != 0);
            push_tx  = 1'b0;
            m_rx_pop = 1'b0;
            case (op)
                0: begin
                    bus_wr(32'h200 + idx, d);
                    ram_m[idx] = d;
                    have_exp = 1'b0;
                end
                1, 7: begin
                    bus_rd(32'h200 + idx);
                    exp_rd = ram_m[idx];
                end
                2, 3, 4: begin
                    if ($urandom_range(0, 3) == 0) d = 8'h00;
                    bus_wr(32'h30000, d);
                    have_exp = 1'b0;
                    push_tx  = (d != 8'h00) && ((txq.size() < 16) || pop_tx);
                end
                5: begin
                    bus_rd(32'h30000);
                    m_rx_pop = (rxq.size() != 0);
                    if (m_rx_pop) exp_rd = rxq[0];
                end
                default: bus_rd(32'h30008 + idx);
            endcase
            if (pop_tx)   void'(txq.pop_front());
            if (push_tx)  txq.push_back(d);
            if (m_rx_pop) void'(rxq.pop_front());
            if (rx_valid) begin
                if (rxq.size() < 8) rxq.push_back(rx_data);
                else                m_ovf = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus (mem_a/mem_dout/mem_wr in, mem_din out).
- Provides 128 KB of byte RAM with 1-cycle read latency.
- Maps the I/O window (mem_a[17:16]==2'b11) to a UART TX FIFO, a UART RX FIFO, a cycle counter and a program-stop flag.
- Drives io_buffer_full back to the CPU; sits beside cpu in the top-level/simulation harness.

Parameters:
- ADDR_W, 17, RAM byte-address width (2^17 bytes).
- TX_DEPTH_LOG, 4, log2 depth of the TX byte FIFO (16 entries).
- RX_DEPTH_LOG, 3, log2 depth of the RX byte FIFO (8 entries).
- FULL_MARGIN, 2, free TX slots at or below which io_buffer_full asserts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- mem_a  in  32  CPU address bus; only [17:0] decoded
- mem_wdata  in  8  CPU write data (CPU mem_dout)
- mem_wr  in  1  1 = write, 0 = read
- mem_rdata  out  8  read data to CPU (CPU mem_din), valid the cycle after the address
- io_buffer_full  out  1  TX FIFO nearly full
- tx_valid  out  1  TX byte available to UART
- tx_data  out  8  TX byte
- tx_ready  in  1  UART accepts the byte this cycle
- rx_valid  in  1  UART delivers a received byte this cycle
- rx_data  in  8  received byte
- rx_overflow  out  1  sticky: an RX byte was dropped because the FIFO was full
- halted  out  1  program-stop seen and TX FIFO drained

Behaviour:
Decode (every cycle):
- io = (mem_a[17:16]==2'b11); otherwise RAM index = mem_a[ADDR_W-1:0].

RAM:
- Write when mem_wr=1 && !io; the byte is stored at the clock edge.
- Read returns array[index] on mem_rdata one cycle later via a registered read.
- Read-after-write to the same address in the next cycle returns the new byte.
- RAM contents are not affected by rst.

I/O writes:
- 0x30000: push mem_wdata into the TX FIFO. A 0x00 write is ignored. A push while the FIFO is full is dropped; the CPU must honour io_buffer_full.
- 0x30004: set stop_req and push 0x00 into the TX FIFO. This push bypasses the 0x00 filter.
- Any other I/O address: no effect.

I/O reads (result registered, returned next cycle):
- 0x30000: pop the RX FIFO and return the byte. Return 0x00 if the FIFO is empty; nothing is popped in that case.
- 0x30004: return cycle_cnt[7:0] and latch snap <= cycle_cnt.
- 0x30005/6/7: return snap[15:8] / [23:16] / [31:24].
- Any other I/O address: 0x00.

Counter and flags:
- cycle_cnt: 32-bit, increments every cycle after reset release, wraps 0xFFFFFFFF -> 0.
- io_buffer_full = (TX_DEPTH - tx_count) <= FULL_MARGIN, driven combinationally from the count register.
- TX FIFO: tx_valid = !empty; tx_data = head; pop on tx_valid && tx_ready.
- Simultaneous TX push and pop: count unchanged, both take effect.
- RX FIFO: push on rx_valid. If the FIFO is full the byte is dropped and rx_overflow is set until rst.
- Simultaneous RX push and pop on a full FIFO: allowed; both succeed.
- halted: set when stop_req && tx FIFO empty; stays set until rst. Writes after the stop still function.

Reset (asynchronous, any cycle, mid-operation included):
- mem_rdata=0, tx_valid=0, io_buffer_full=0, rx_overflow=0, halted=0.
- FIFO pointers and counts, cycle_cnt, snap and stop_req all cleared.
- An in-flight read returns 0.

Optional Feature:
- MEM_INIT_EN defined: RAM is initialised at elaboration by $readmemh from string parameter INIT_FILE (default "test.data").
- MEM_INIT_EN undefined: RAM starts uninitialised (X in simulation), no file access, and parameter INIT_FILE is absent.

Decomposition:
- Shared package mem_io_pkg: IO_BASE_SEL (2'b11), ADDR_UART (0x30000), ADDR_CLK_STOP (0x30004), byte_t, word_t.
- One sub-module, byte_fifo (parameter DEPTH_LOG; push/pop/full/empty/count/head). Instantiated twice, for TX and RX.
- RAM array, decode, read mux and counter stay in mem_io_responder.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 next cycle -> mem_rdata=0xA5 exactly one cycle after the read address.
- Write 0x48, 0x00, 0x69 to 0x30000 with tx_ready=1 -> tx_data sequence 0x48, 0x69; the 0x00 is never emitted.
- Hold tx_ready=0 and write 14 non-zero bytes to 0x30000 -> io_buffer_full rises after the 14th push (2 free); the 17th push is dropped and tx_count stays 16.
- Release rst at cycle 0, read 0x30004 at cycle 0x1234, then 0x30005 -> returns 0x34 then 0x12. Force cycle_cnt to 0xFFFFFFFF and step one cycle -> wraps to 0.
- rx_valid with 9 bytes into the empty FIFO, no reads -> rx_overflow=1. Nine reads of 0x30000 return bytes 1..8 then 0x00.
- Write 0x30004 with 3 bytes pending in TX, tx_ready=1 -> 0x00 emitted last; halted rises the cycle the FIFO empties. Assert rst mid-stream -> all outputs return to 0 immediately.
